// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared state encoding and defaults for the PC sequencer.
// Revision 1.0
`default_nettype none

package pc_seq_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 8;
  localparam int START_PC  = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter -- saturating up-counter with synchronous clear.
// Revision 1.0
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch-PC sequencer with one-bubble table-driven branch redirect.
// Revision 1.0
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HaltReq,
  input  logic             Stall,
  input  logic             BranchReq,
  input  logic             BranchTaken,
  input  logic [3:0]       BranchPtr,
  output logic [3:0]       LutAddr,
  input  logic [PC_W-1:0]  LutTarget,
  output logic [PC_W-1:0]  ProgCounter,
  output logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] BranchCount
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] branch_pc, branch_pc_nxt;
  logic [3:0]      lut_addr_nxt;
  logic            cnt_clr, cnt_inc;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ProgCounter <= PC_W'(START_PC);
      branch_pc   <= '0;
      LutAddr     <= '0;
    end else begin
      ProgCounter <= pc_nxt;
      branch_pc   <= branch_pc_nxt;
      LutAddr     <= lut_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = ProgCounter;
    branch_pc_nxt = branch_pc;
    lut_addr_nxt  = LutAddr;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_nxt = ST_RUN;
          pc_nxt    = PC_W'(START_PC);
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (HaltReq) begin
          state_nxt = ST_HALTED;
        end else if (Stall) begin
          state_nxt = ST_RUN;
        end else if (BranchReq && BranchTaken) begin
          state_nxt     = ST_REDIRECT;
          lut_addr_nxt  = BranchPtr;
          branch_pc_nxt = ProgCounter;
        end else begin
          pc_nxt = ProgCounter + PC_W'(1);
        end
      end
      ST_REDIRECT: begin
        // Offset is already PC_W wide, so a plain add is the sign-extended modular sum.
        if (!Stall) begin
          state_nxt = ST_RUN;
          pc_nxt    = branch_pc + LutTarget;
          cnt_inc   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Flush = (state == ST_REDIRECT);
    Busy  = (state == ST_RUN) || (state == ST_REDIRECT);
    Done  = (state == ST_HALTED);
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_branch_cnt (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (BranchCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed scoreboard bench for pc_sequencer.
// Revision 1.0
`default_nettype none

module tb_pc_sequencer;

  logic       Clk, Reset, Start, HaltReq, Stall, BranchReq, BranchTaken;
  logic [3:0] BranchPtr, LutAddr;
  logic [9:0] LutTarget, ProgCounter;
  logic       Flush, Busy, Done;
  logic [7:0] BranchCount;
  logic [9:0] lut [16];

  pc_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .HaltReq     (HaltReq),
    .Stall       (Stall),
    .BranchReq   (BranchReq),
    .BranchTaken (BranchTaken),
    .BranchPtr   (BranchPtr),
    .LutAddr     (LutAddr),
    .LutTarget   (LutTarget),
    .ProgCounter (ProgCounter),
    .Flush       (Flush),
    .Busy        (Busy),
    .Done        (Done),
    .BranchCount (BranchCount)
  );

  assign LutTarget = lut[LutAddr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam int SIG_PC = 0, SIG_FLUSH = 1, SIG_BUSY = 2, SIG_DONE = 3, SIG_CNT = 4, SIG_LA = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      SIG_PC:    return {22'd0, ProgCounter};
      SIG_FLUSH: return {31'd0, Flush};
      SIG_BUSY:  return {31'd0, Busy};
      SIG_DONE:  return {31'd0, Done};
      SIG_CNT:   return {24'd0, BranchCount};
      default:   return {28'd0, LutAddr};
    endcase
  endfunction

  task automatic push(string tag, int sig, int exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step();
    tick();
    drain();
  endtask

  task automatic push_state(string tag, int pc, int flush, int busy, int done);
    push({tag, "_pc"}, SIG_PC, pc);
    push({tag, "_flush"}, SIG_FLUSH, flush);
    push({tag, "_busy"}, SIG_BUSY, busy);
    push({tag, "_done"}, SIG_DONE, done);
  endtask

  task automatic clear_inputs();
    Start = 0; HaltReq = 0; Stall = 0; BranchReq = 0; BranchTaken = 0; BranchPtr = 0;
  endtask

  task automatic take_branch(int ptr);
    BranchReq = 1; BranchTaken = 1; BranchPtr = 4'(ptr);
  endtask

  task automatic push_reset_values(string tag);
    push_state(tag, 0, 0, 0, 0);
    push({tag, "_cnt"}, SIG_CNT, 0);
    push({tag, "_la"}, SIG_LA, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lut[i] = '0;
    lut[1] = 10'(-278);
    lut[2] = 10'd276;
    lut[3] = 10'd0;
    lut[4] = 10'd100;
    lut[6] = 10'd1;
    clear_inputs();
    Reset = 0;
    #2;
    push_reset_values("reset");
    drain();
    tick();
    Reset = 1;

    // Noise on every control except Start must not leave IDLE.
    HaltReq = 1; Stall = 1; take_branch(5);
    push_state("idle_hold", 0, 0, 0, 0);
    push("idle_la", SIG_LA, 0);
    step();
    step();
    clear_inputs();

    Start = 1;
    push_state("start", 0, 0, 1, 0);
    step();
    Start = 0;
    for (int i = 1; i <= 5; i++) begin
      push_state("run_inc", i, 0, 1, 0);
      step();
    end

    for (int i = 0; i < 295; i++) tick();
    push("at300", SIG_PC, 300);
    drain();
    take_branch(1);
    push_state("br1_redir", 300, 1, 1, 0);
    push("br1_la", SIG_LA, 1);
    step();
    clear_inputs();
    push_state("br1_target", 22, 0, 1, 0);
    push("br1_cnt", SIG_CNT, 1);
    step();

    BranchReq = 1; BranchTaken = 0;
    push_state("not_taken", 23, 0, 1, 0);
    step();
    BranchReq = 0; BranchTaken = 1;
    push_state("unqualified", 24, 0, 1, 0);
    step();
    clear_inputs();

    for (int i = 0; i < 976; i++) tick();
    push("at1000", SIG_PC, 1000);
    drain();
    take_branch(2);
    push_state("br2_redir", 1000, 1, 1, 0);
    step();
    clear_inputs();
    push_state("br2_wrap", 252, 0, 1, 0);
    push("br2_cnt", SIG_CNT, 2);
    step();

    for (int i = 0; i < 771; i++) tick();
    push("at1023", SIG_PC, 1023);
    drain();
    push_state("pc_wrap", 0, 0, 1, 0);
    step();
    push("pc1", SIG_PC, 1);
    step();

    take_branch(3);
    push_state("self_redir", 1, 1, 1, 0);
    step();
    clear_inputs();
    push_state("self_loop", 1, 0, 1, 0);
    push("self_cnt", SIG_CNT, 3);
    step();
    push("pc2", SIG_PC, 2);
    step();

    take_branch(4);
    push_state("stall_redir", 2, 1, 1, 0);
    push("stall_la", SIG_LA, 4);
    step();
    // Stall holds REDIRECT; branch inputs here must be ignored.
    Stall = 1; take_branch(7);
    for (int i = 0; i < 3; i++) begin
      push_state("stall_hold", 2, 1, 1, 0);
      push("stall_la_hold", SIG_LA, 4);
      push("stall_cnt", SIG_CNT, 3);
      step();
    end
    clear_inputs();
    HaltReq = 1;
    push_state("redir_done", 102, 0, 1, 0);
    push("redir_cnt", SIG_CNT, 4);
    step();

    HaltReq = 1; Stall = 1; take_branch(5);
    push_state("halt_prio", 102, 0, 0, 1);
    push("halt_la", SIG_LA, 4);
    step();
    clear_inputs();
    push_state("halt_hold", 102, 0, 0, 1);
    step();

    Start = 1;
    push_state("restart", 0, 0, 1, 0);
    push("restart_cnt", SIG_CNT, 0);
    step();
    clear_inputs();

    for (int i = 0; i < 260; i++) begin
      take_branch(6);
      tick();
      clear_inputs();
      tick();
      if (i == 254) begin
        push("cnt_reach255", SIG_CNT, 255);
        drain();
      end
    end
    push("cnt_sat", SIG_CNT, 255);
    push("sat_pc", SIG_PC, 260);
    drain();

    HaltReq = 1;
    push_state("sat_halt", 260, 0, 0, 1);
    push("sat_halt_cnt", SIG_CNT, 255);
    step();
    HaltReq = 0; Start = 1;
    push_state("sat_restart", 0, 0, 1, 0);
    push("sat_restart_cnt", SIG_CNT, 0);
    step();
    clear_inputs();
    push("pc1_again", SIG_PC, 1);
    step();

    take_branch(1);
    push_state("rst_redir", 1, 1, 1, 0);
    step();
    clear_inputs();
    #3;
    Reset = 0;
    #1;
    push_reset_values("async_rst");
    drain();
    tick();
    Reset = 1;
    for (int i = 0; i < 3; i++) begin
      push_reset_values("post_rst_idle");
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
